// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and saturating-counter helpers for the pattern table
package bp_pkg;

    localparam int CTR_WIDTH_MAX = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_t;

    // Weakly-not-taken value: MSB clear, all lower bits set.
    function automatic int unsigned weak_nt(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // Strongly-taken value: all bits set.
    function automatic int unsigned ctr_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // One saturating step; bounds are checked before the add/subtract so nothing wraps.
    function automatic logic [CTR_WIDTH_MAX-1:0] ctr_next(
        input logic [CTR_WIDTH_MAX-1:0] ctr,
        input logic                     taken,
        input int unsigned              width
    );
        logic [CTR_WIDTH_MAX-1:0] max_v;
        max_v = CTR_WIDTH_MAX'(ctr_max(width));
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + 4'd1;
        end
        return (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/bp_pattern_table_ctr_ram.sv
// rtl/bp_pattern_table_ctr_ram.sv - counter array, two async read ports, one sync write port
module bp_ctr_ram #(
    parameter int CTR_WIDTH  = 2,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] rd_a_index,
    output logic [CTR_WIDTH-1:0]  rd_a_data,
    input  logic [INDEX_BITS-1:0] rd_b_index,
    output logic [CTR_WIDTH-1:0]  rd_b_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [CTR_WIDTH-1:0]  wr_data
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [CTR_WIDTH-1:0] mem [DEPTH];

    // Single write port; the table has no reset, the init walk fills it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_index] <= wr_data;
        end
    end

    // Port A feeds prediction, port B feeds the update read-modify-write.
    assign rd_a_data = mem[rd_a_index];
    assign rd_b_data = mem[rd_b_index];

endmodule

// File: rtl/bp_pattern_table.sv
// rtl/bp_pattern_table.sv - bimodal/gshare branch direction predictor with init walk
module bp_pattern_table
    import bp_pkg::*;
#(
    parameter int CTR_WIDTH  = 2,
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 4,
    parameter int PC_BITS    = 16,
    parameter int PC_LSB     = 0,
    parameter int MODE       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_BITS-1:0]    pred_pc,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    output logic                  ready,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    output logic [HIST_BITS-1:0]  ghr
);

    localparam logic [CTR_WIDTH-1:0] WEAK_NT = CTR_WIDTH'(weak_nt(CTR_WIDTH));

    bp_state_t             state, state_d;
    logic [INDEX_BITS-1:0] init_ptr, init_ptr_d;
    logic [HIST_BITS-1:0]  ghr_d;
    logic                  ready_d;

    logic [CTR_WIDTH-1:0]  pred_ctr;
    logic [CTR_WIDTH-1:0]  upd_ctr;
    logic [CTR_WIDTH-1:0]  upd_next;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_index;
    logic [CTR_WIDTH-1:0]  wr_data;
    logic                  unused_bits;

    // Index hash: PC slice, optionally folded with history aligned to the LSBs.
    always_comb begin
        pred_index = pred_pc[PC_LSB +: INDEX_BITS];
        if (MODE == 1) begin
            pred_index = pred_index ^ INDEX_BITS'(ghr);
        end
    end

    assign upd_next    = CTR_WIDTH'(ctr_next(CTR_WIDTH_MAX'(upd_ctr), upd_taken, CTR_WIDTH));
    assign pred_taken  = (state == RUN) && pred_ctr[CTR_WIDTH-1];
    assign unused_bits = ^{pred_pc, pred_ctr};

    bp_ctr_ram #(
        .CTR_WIDTH  (CTR_WIDTH),
        .INDEX_BITS (INDEX_BITS)
    ) u_ram (
        .clk        (clk),
        .rd_a_index (pred_index),
        .rd_a_data  (pred_ctr),
        .rd_b_index (upd_index),
        .rd_b_data  (upd_ctr),
        .wr_en      (wr_en && !rst),
        .wr_index   (wr_index),
        .wr_data    (wr_data)
    );

    // State register; reset restarts the walk from entry 0 and clears history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_ptr <= '0;
            ghr      <= '0;
            ready    <= 1'b0;
        end else begin
            state    <= state_d;
            init_ptr <= init_ptr_d;
            ghr      <= ghr_d;
            ready    <= ready_d;
        end
    end

    // Next state and write-port mux: walk writes in INIT, resolved branches in RUN.
    always_comb begin
        state_d    = state;
        init_ptr_d = init_ptr;
        ghr_d      = ghr;
        ready_d    = ready;
        wr_en      = 1'b0;
        wr_index   = init_ptr;
        wr_data    = WEAK_NT;
        case (state)
            INIT: begin
                wr_en      = 1'b1;
                init_ptr_d = init_ptr + 1'b1;
                if (init_ptr == '1) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                if (upd_valid) begin
                    wr_en    = 1'b1;
                    wr_index = upd_index;
                    wr_data  = upd_next;
                    ghr_d    = (ghr << 1) | HIST_BITS'(upd_taken);
                end
            end
            default: state_d = INIT;
        endcase
    end

endmodule

// File: tb/tb_bp_pattern_table.sv
// tb/tb_bp_pattern_table.sv - scoreboard bench for bp_pattern_table (gshare, bimodal, 3-bit)
module tb_bp_pattern_table;

    localparam int S_PT  = 0;
    localparam int S_PI  = 1;
    localparam int S_RDY = 2;
    localparam int S_GHR = 3;

    // Expected pred_taken per step for the saturation runs, bit i = step i.
    localparam bit [9:0]  SAT2 = 10'b0000111110;
    localparam bit [15:0] SAT3 = 16'h03FE;
    localparam bit [3:0]  HIST = 4'b1101;

    typedef struct {
        int          d;
        int          sig;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic        clk;
    logic        rst_v [3];
    logic [15:0] pc    [3];
    logic        uv    [3];
    logic [5:0]  ui    [3];
    logic        ut    [3];

    logic       pt_a, pt_b, pt_c;
    logic [5:0] pi_a, pi_b;
    logic [3:0] pi_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [3:0] ghr_a, ghr_b, ghr_c;

    chk_t        sb [$];
    chk_t        cur;
    logic [15:0] act;
    int          n_tests = 0;
    int          n_fail  = 0;

    bp_pattern_table #(.MODE(1)) dut_a (
        .clk(clk), .rst(rst_v[0]), .pred_pc(pc[0]), .pred_taken(pt_a), .pred_index(pi_a),
        .ready(rdy_a), .upd_valid(uv[0]), .upd_index(ui[0]), .upd_taken(ut[0]), .ghr(ghr_a)
    );

    bp_pattern_table #(.MODE(0)) dut_b (
        .clk(clk), .rst(rst_v[1]), .pred_pc(pc[1]), .pred_taken(pt_b), .pred_index(pi_b),
        .ready(rdy_b), .upd_valid(uv[1]), .upd_index(ui[1]), .upd_taken(ut[1]), .ghr(ghr_b)
    );

    bp_pattern_table #(.CTR_WIDTH(3), .INDEX_BITS(4), .HIST_BITS(4), .MODE(0)) dut_c (
        .clk(clk), .rst(rst_v[2]), .pred_pc(pc[2]), .pred_taken(pt_c), .pred_index(pi_c),
        .ready(rdy_c), .upd_valid(uv[2]), .upd_index(ui[2][3:0]), .upd_taken(ut[2]), .ghr(ghr_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] get_sig(input int d, input int s);
        logic [15:0] r;
        r = '0;
        case (d)
            0: case (s)
                S_PT:    r = 16'(pt_a);
                S_PI:    r = 16'(pi_a);
                S_RDY:   r = 16'(rdy_a);
                default: r = 16'(ghr_a);
            endcase
            1: case (s)
                S_PT:    r = 16'(pt_b);
                S_PI:    r = 16'(pi_b);
                S_RDY:   r = 16'(rdy_b);
                default: r = 16'(ghr_b);
            endcase
            default: case (s)
                S_PT:    r = 16'(pt_c);
                S_PI:    r = 16'(pi_c);
                S_RDY:   r = 16'(rdy_c);
                default: r = 16'(ghr_c);
            endcase
        endcase
        return r;
    endfunction

    task automatic chk(input int d, input int s, input logic [15:0] e, input string n);
        chk_t c;
        c.d    = d;
        c.sig  = s;
        c.exp  = e;
        c.name = n;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: drain everything queued this cycle and compare against live outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            act = get_sig(cur.d, cur.sig);
            n_tests++;
            if (act !== cur.exp) begin
                n_fail++;
                $display("FAIL %s (dut %0d): got %0h expected %0h at %0t",
                         cur.name, cur.d, act, cur.exp, $time);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_v[d] = 1'b1;
            pc[d]    = '0;
            uv[d]    = 1'b0;
            ui[d]    = '0;
            ut[d]    = 1'b0;
        end
        step();
        step();
        for (int d = 0; d < 3; d++) rst_v[d] = 1'b0;

        // Reset and walk: 64 entries for the default tables, 16 for the narrow one.
        for (int k = 0; k <= 64; k++) begin
            pc[0] = 16'(k & 63);
            chk(0, S_RDY, 16'(k == 64), "walk_ready_a");
            chk(1, S_RDY, 16'(k == 64), "walk_ready_b");
            chk(2, S_RDY, 16'(k >= 16), "walk_ready_c");
            if (k == 10) begin
                chk(0, S_PI, 16'd10, "init_pred_index");
                chk(0, S_PT, 16'd0, "init_pred_taken");
            end
            step();
        end
        chk(0, S_GHR, 16'd0, "reset_ghr_a");
        for (int p = 0; p < 64; p++) begin
            pc[0] = 16'(p);
            chk(0, S_PT, 16'd0, "walk_pred_taken");
            chk(0, S_PI, 16'(p), "walk_pred_index");
            step();
        end

        // Bimodal 2-bit saturation on index 5.
        for (int i = 0; i < 10; i++) begin
            pc[1] = 16'h0005;
            uv[1] = (i < 9);
            ui[1] = 6'd5;
            ut[1] = (i < 4);
            chk(1, S_PT, 16'(SAT2[i]), "sat2_pred_taken");
            chk(1, S_PI, 16'd5, "sat2_pred_index");
            if (i == 4) chk(1, S_GHR, 16'hF, "sat2_ghr_taken");
            step();
        end
        uv[1] = 1'b0;
        chk(1, S_GHR, 16'h0, "sat2_ghr_nt");
        step();

        // 3-bit counters: reset value 011, saturate at 111 and 000.
        for (int i = 0; i < 16; i++) begin
            pc[2] = 16'h0005;
            uv[2] = (i < 15);
            ui[2] = 6'd5;
            ut[2] = (i < 6);
            chk(2, S_PT, 16'(SAT3[i]), "sat3_pred_taken");
            step();
        end
        uv[2] = 1'b0;
        chk(2, S_GHR, 16'h0, "sat3_ghr");
        step();

        // gshare history and hashing.
        for (int i = 0; i < 4; i++) begin
            uv[0] = 1'b1;
            ui[0] = 6'(20 + i);
            ut[0] = HIST[i];
            step();
        end
        uv[0] = 1'b0;
        pc[0] = 16'h0003;
        chk(0, S_GHR, 16'hB, "gshare_ghr");
        chk(0, S_PI, 16'h08, "gshare_pred_index");
        chk(0, S_PT, 16'd0, "gshare_pred_taken");
        step();

        // Same-cycle collision on index 9: old value now, new value next cycle.
        pc[0] = 16'h0002;
        uv[0] = 1'b1;
        ui[0] = 6'd9;
        ut[0] = 1'b1;
        chk(0, S_PI, 16'd9, "collide_index");
        chk(0, S_PT, 16'd0, "collide_same_cycle");
        step();
        uv[0] = 1'b0;
        pc[0] = 16'h000E;
        chk(0, S_GHR, 16'h7, "collide_ghr");
        chk(0, S_PI, 16'd9, "collide_next_index");
        chk(0, S_PT, 16'd1, "collide_next_cycle");
        step();

        // Reset mid-walk, with updates offered during INIT that must be ignored.
        rst_v[0] = 1'b1;
        step();
        step();
        rst_v[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            uv[0] = 1'b1;
            ui[0] = 6'd8;
            ut[0] = 1'b1;
            chk(0, S_RDY, 16'd0, "midwalk_ready");
            chk(0, S_GHR, 16'd0, "midwalk_ghr");
            step();
        end
        rst_v[0] = 1'b1;
        step();
        rst_v[0] = 1'b0;
        for (int k = 0; k <= 64; k++) begin
            uv[0] = (k < 64);
            chk(0, S_RDY, 16'(k == 64), "rewalk_ready");
            chk(0, S_GHR, 16'd0, "rewalk_ghr");
            step();
        end
        for (int i = 0; i < 3; i++) begin
            uv[0] = 1'b1;
            ui[0] = 6'd8;
            ut[0] = 1'b1;
            pc[0] = 16'(8 ^ ((1 << i) - 1));
            chk(0, S_PI, 16'd8, "run_upd_index");
            chk(0, S_PT, 16'(i != 0), "run_upd_taken");
            step();
        end
        uv[0] = 1'b0;
        pc[0] = 16'h000F;
        chk(0, S_GHR, 16'h7, "run_ghr");
        chk(0, S_PT, 16'd1, "run_strong_taken");
        step();

        // Reset from RUN: walk restarts, history and entries return to reset values.
        rst_v[0] = 1'b1;
        step();
        step();
        rst_v[0] = 1'b0;
        for (int k = 0; k <= 64; k++) begin
            chk(0, S_RDY, 16'(k == 64), "runrst_ready");
            step();
        end
        pc[0] = 16'h0008;
        uv[0] = 1'b1;
        ui[0] = 6'd8;
        ut[0] = 1'b1;
        chk(0, S_GHR, 16'd0, "runrst_ghr");
        chk(0, S_PT, 16'd0, "runrst_entry_nt");
        step();
        uv[0] = 1'b0;
        pc[0] = 16'h0009;
        chk(0, S_PI, 16'd8, "runrst_index");
        chk(0, S_PT, 16'd1, "runrst_entry_weak");
        step();

        step();
        step();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
